// File: rtl/strobe_sched.sv
// Base-tick prescaler feeding per-channel strobe dividers, configured through a
// two-state valid/ready handshake; sync realigns every counter to a common phase.
module strobe_sched #(
    parameter int clk_mhz = 50,
    parameter int base_hz = 1000,
    parameter int n_ch    = 4,
    parameter int w_div   = 8
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      sync,
    input  logic                                      cfg_valid,
    output logic                                      cfg_ready,
    input  logic [((n_ch > 1) ? $clog2(n_ch) : 1)-1:0] cfg_ch,
    input  logic [w_div-1:0]                          cfg_div,
    input  logic                                      cfg_en,
    output logic                                      tick,
    output logic [n_ch-1:0]                           strobe,
    output logic [n_ch-1:0]                           en_mask
);

    // state | meaning
    // IDLE  | ready for a config request
    // APPLY | writing the captured config into its channel
    typedef enum logic {IDLE, APPLY} cfg_state_t;

    localparam int period = clk_mhz * 1000000 / base_hz;
    localparam int pw     = (period < 2) ? 1 : $clog2(period);
    localparam int cw     = (n_ch > 1) ? $clog2(n_ch) : 1;
    localparam logic [pw-1:0] reload = pw'((period < 1) ? 0 : period - 1);

    logic [pw-1:0]    pre_cnt;
    logic             tick_q;

    cfg_state_t       state;
    cfg_state_t       state_nxt;
    logic             rdy_q;
    logic             capture;
    logic [cw-1:0]    cap_ch;
    logic [w_div-1:0] cap_div;
    logic             cap_en;
    logic [n_ch-1:0]  apply_sel;

    logic [w_div-1:0] div_q [n_ch];
    logic [w_div-1:0] cnt_q [n_ch];
    logic [n_ch-1:0]  en_q;
    logic [n_ch-1:0]  strobe_q;

    assign tick    = tick_q;
    assign strobe  = strobe_q;
    assign en_mask = en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            tick_q  <= 1'b0;
        end else if (sync) begin
            pre_cnt <= '0;
            tick_q  <= 1'b0;
        end else if (pre_cnt == '0) begin
            pre_cnt <= reload;
            tick_q  <= 1'b1;
        end else begin
            pre_cnt <= pre_cnt - pw'(1);
            tick_q  <= 1'b0;
        end
    end

    // rdy_q keeps cfg_ready low until the first edge after reset release
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        cfg_ready = rdy_q && (state == IDLE);
        case (state)
            IDLE: begin
                if (cfg_valid && cfg_ready) begin
                    capture   = 1'b1;
                    state_nxt = APPLY;
                end
            end
            APPLY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rdy_q   <= 1'b0;
            cap_ch  <= '0;
            cap_div <= '0;
            cap_en  <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy_q <= 1'b1;
            if (capture) begin
                cap_ch  <= cfg_ch;
                cap_div <= cfg_div;
                cap_en  <= cfg_en;
            end
        end
    end

    // an out-of-range channel index matches no channel, so APPLY is a no-op
    always_comb begin
        apply_sel = '0;
        for (int i = 0; i < n_ch; i++) begin
            if ((state == APPLY) && (32'(cap_ch) == 32'(i)))
                apply_sel[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < n_ch; i++) begin
                div_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            en_q     <= '0;
            strobe_q <= '0;
        end else begin
            for (int i = 0; i < n_ch; i++) begin
                if (apply_sel[i]) begin
                    div_q[i] <= cap_div;
                    en_q[i]  <= cap_en;
                end
                if (sync || apply_sel[i]) begin
                    cnt_q[i]    <= '0;
                    strobe_q[i] <= 1'b0;
                end else if (tick_q && en_q[i]) begin
                    if (cnt_q[i] == '0) begin
                        cnt_q[i]    <= div_q[i];
                        strobe_q[i] <= 1'b1;
                    end else begin
                        cnt_q[i]    <= cnt_q[i] - w_div'(1);
                        strobe_q[i] <= 1'b0;
                    end
                end else begin
                    strobe_q[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_strobe_sched.sv
// Directed bench for strobe_sched at period 4 with three channels.
module tb_strobe_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sync;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       cfg_en;
    logic       tick;
    logic [2:0] strobe;
    logic [2:0] en_mask;

    int compared   = 0;
    int mismatched = 0;
    int cyc;
    int tph = 1;
    // shared phase of channels after the sync realignment
    logic g_prev = 1'b0;
    int   g_j    = 0;

    strobe_sched #(.clk_mhz(1), .base_hz(250000), .n_ch(3), .w_div(8)) dut (
        .clk(clk), .rst_n(rst_n), .sync(sync), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_en(cfg_en),
        .tick(tick), .strobe(strobe), .en_mask(en_mask)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        logic exp_t;
        rst_n = 1'b0; sync = 1'b0; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_div = '0; cfg_en = 1'b0;
        repeat (3) @(negedge clk);
        compared += 4;
        if (tick !== 1'b0)      begin mismatched++; $display("FAIL rst_tick got %b want 0", tick); end
        if (strobe !== 3'b000)  begin mismatched++; $display("FAIL rst_strobe got %b want 000", strobe); end
        if (en_mask !== 3'b000) begin mismatched++; $display("FAIL rst_en_mask got %b want 000", en_mask); end
        if (cfg_ready !== 1'b0) begin mismatched++; $display("FAIL rst_ready got %b want 0", cfg_ready); end
        rst_n = 1'b1;
        for (int it = 0; it < 13; it++) begin
            @(negedge clk);
            exp_t = (cyc % 4 == tph);
            compared += 4;
            if (tick !== exp_t)     begin mismatched++; $display("FAIL boot_tick cyc=%0d got %b want %b", cyc, tick, exp_t); end
            if (strobe !== 3'b000)  begin mismatched++; $display("FAIL boot_strobe cyc=%0d got %b want 000", cyc, strobe); end
            if (en_mask !== 3'b000) begin mismatched++; $display("FAIL boot_en_mask cyc=%0d got %b want 000", cyc, en_mask); end
            if (cfg_ready !== 1'b1) begin mismatched++; $display("FAIL boot_ready cyc=%0d got %b want 1", cyc, cfg_ready); end
        end
    endtask

    task automatic test_single_channel();
        logic exp_t, exp_s, prev0;
        logic [2:0] exp_m;
        int k0;
        prev0 = 1'b0; k0 = 0;
        for (int it = 0; it < 40; it++) begin
            exp_t = (cyc % 4 == tph);
            exp_s = prev0 && (k0 % 3 == 0);
            exp_m = (it >= 2) ? 3'b001 : 3'b000;
            compared += 3;
            if (tick !== exp_t)              begin mismatched++; $display("FAIL ch0_tick it=%0d got %b want %b", it, tick, exp_t); end
            if (strobe !== {2'b00, exp_s})   begin mismatched++; $display("FAIL ch0_strobe it=%0d got %b want %b", it, strobe, {2'b00, exp_s}); end
            if (en_mask !== exp_m)           begin mismatched++; $display("FAIL ch0_en_mask it=%0d got %b want %b", it, en_mask, exp_m); end
            if (it < 3) begin
                compared++;
                if (cfg_ready !== (it != 1)) begin mismatched++; $display("FAIL ch0_ready it=%0d got %b want %b", it, cfg_ready, (it != 1)); end
            end
            if (prev0) k0++;
            prev0 = (it >= 2) ? exp_t : 1'b0;
            if (it == 0) begin cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2; cfg_en = 1'b1; end
            if (it == 1) cfg_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_t, exp1, exp2, prev1, prev2;
        logic [2:0] exp_m;
        logic exp_r;
        int k2;
        prev1 = 1'b0; prev2 = 1'b0; k2 = 0;
        for (int it = 0; it < 24; it++) begin
            exp_t = (cyc % 4 == tph);
            exp1  = prev1;
            exp2  = prev2 && (k2 % 2 == 0);
            exp_m = (it >= 4) ? 3'b111 : (it >= 2) ? 3'b011 : 3'b001;
            exp_r = (it != 1) && (it != 3);
            compared += 5;
            if (tick !== exp_t)      begin mismatched++; $display("FAIL b2b_tick it=%0d got %b want %b", it, tick, exp_t); end
            if (strobe[1] !== exp1)  begin mismatched++; $display("FAIL b2b_strobe1 it=%0d got %b want %b", it, strobe[1], exp1); end
            if (strobe[2] !== exp2)  begin mismatched++; $display("FAIL b2b_strobe2 it=%0d got %b want %b", it, strobe[2], exp2); end
            if (en_mask !== exp_m)   begin mismatched++; $display("FAIL b2b_en_mask it=%0d got %b want %b", it, en_mask, exp_m); end
            if (cfg_ready !== exp_r) begin mismatched++; $display("FAIL b2b_ready it=%0d got %b want %b", it, cfg_ready, exp_r); end
            if (prev2) k2++;
            prev1 = (it >= 2) ? exp_t : 1'b0;
            prev2 = (it >= 4) ? exp_t : 1'b0;
            if (it == 0) begin cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd0; cfg_en = 1'b1; end
            if (it == 1) begin cfg_ch = 2'd2; cfg_div = 8'd1; end
            if (it == 3) cfg_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_sync();
        logic exp_t;
        logic [2:0] exp_s;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (tick === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        compared++;
        if (!found) begin mismatched++; $display("FAIL sync_wait_tick got no tick within 8 cycles want tick"); end
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        compared += 2;
        if (tick !== 1'b0)     begin mismatched++; $display("FAIL sync_tick_off got %b want 0", tick); end
        if (strobe !== 3'b000) begin mismatched++; $display("FAIL sync_no_strobe got %b want 000", strobe); end
        @(negedge clk);
        compared += 2;
        if (tick !== 1'b1)     begin mismatched++; $display("FAIL sync_tick_resume got %b want 1", tick); end
        if (strobe !== 3'b000) begin mismatched++; $display("FAIL sync_strobe_gap got %b want 000", strobe); end
        tph = cyc % 4;
        g_prev = 1'b1; g_j = 0;
        @(negedge clk);
        for (int it = 0; it < 48; it++) begin
            exp_t = (cyc % 4 == tph);
            exp_s = {g_prev && (g_j % 2 == 0), g_prev, g_prev && (g_j % 3 == 0)};
            compared += 2;
            if (tick !== exp_t)  begin mismatched++; $display("FAIL sync_phase_tick it=%0d got %b want %b", it, tick, exp_t); end
            if (strobe !== exp_s) begin mismatched++; $display("FAIL sync_aligned it=%0d got %b want %b", it, strobe, exp_s); end
            if (g_prev) g_j++;
            g_prev = exp_t;
            @(negedge clk);
        end
    endtask

    task automatic test_invalid_and_disable();
        logic exp_t, exp_r;
        logic [2:0] exp_s, exp_m;
        for (int it = 0; it < 40; it++) begin
            exp_t = (cyc % 4 == tph);
            exp_s = {g_prev && (g_j % 2 == 0), g_prev, g_prev && (g_j % 3 == 0) && (it < 12)};
            exp_m = (it >= 12) ? 3'b110 : 3'b111;
            exp_r = (it != 1) && (it != 11);
            compared += 4;
            if (tick !== exp_t)      begin mismatched++; $display("FAIL inv_tick it=%0d got %b want %b", it, tick, exp_t); end
            if (strobe !== exp_s)    begin mismatched++; $display("FAIL inv_dis_strobe it=%0d got %b want %b", it, strobe, exp_s); end
            if (en_mask !== exp_m)   begin mismatched++; $display("FAIL inv_dis_en_mask it=%0d got %b want %b", it, en_mask, exp_m); end
            if (cfg_ready !== exp_r) begin mismatched++; $display("FAIL inv_dis_ready it=%0d got %b want %b", it, cfg_ready, exp_r); end
            if (g_prev) g_j++;
            g_prev = exp_t;
            if (it == 0)  begin cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd5; cfg_en = 1'b1; end
            if (it == 1)  cfg_valid = 1'b0;
            if (it == 10) begin cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2; cfg_en = 1'b0; end
            if (it == 11) cfg_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_div_max();
        logic exp_t, exp0, prev0;
        logic [2:0] exp_s, exp_m;
        int k0, n_str;
        prev0 = 1'b0; k0 = 0; n_str = 0;
        for (int it = 0; it < 1040; it++) begin
            exp_t = (cyc % 4 == tph);
            exp0  = prev0 && (k0 % 256 == 0);
            exp_s = {g_prev && (g_j % 2 == 0), g_prev, exp0};
            exp_m = (it >= 2) ? 3'b111 : 3'b110;
            compared += 3;
            if (tick !== exp_t)    begin mismatched++; $display("FAIL max_tick it=%0d got %b want %b", it, tick, exp_t); end
            if (strobe !== exp_s)  begin mismatched++; $display("FAIL max_strobe it=%0d got %b want %b", it, strobe, exp_s); end
            if (en_mask !== exp_m) begin mismatched++; $display("FAIL max_en_mask it=%0d got %b want %b", it, en_mask, exp_m); end
            if (strobe[0] === 1'b1) n_str++;
            if (prev0) k0++;
            prev0 = (it >= 2) ? exp_t : 1'b0;
            if (g_prev) g_j++;
            g_prev = exp_t;
            if (it == 0) begin cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd255; cfg_en = 1'b1; end
            if (it == 1) cfg_valid = 1'b0;
            @(negedge clk);
        end
        compared++;
        if (n_str != 2) begin mismatched++; $display("FAIL max_strobe_count got %0d want 2", n_str); end
    endtask

    task automatic test_reset_in_apply();
        logic exp_t;
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd0; cfg_en = 1'b0;
        @(negedge clk);
        compared++;
        if (cfg_ready !== 1'b0) begin mismatched++; $display("FAIL rapply_ready got %b want 0", cfg_ready); end
        #2;
        rst_n = 1'b0;
        cfg_valid = 1'b0;
        #1;
        compared += 4;
        if (tick !== 1'b0)      begin mismatched++; $display("FAIL rapply_tick got %b want 0", tick); end
        if (strobe !== 3'b000)  begin mismatched++; $display("FAIL rapply_strobe got %b want 000", strobe); end
        if (en_mask !== 3'b000) begin mismatched++; $display("FAIL rapply_en_mask got %b want 000", en_mask); end
        if (cfg_ready !== 1'b0) begin mismatched++; $display("FAIL rapply_ready_rst got %b want 0", cfg_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tph = 1;
        for (int it = 0; it < 16; it++) begin
            @(negedge clk);
            exp_t = (cyc % 4 == tph);
            compared += 4;
            if (tick !== exp_t)     begin mismatched++; $display("FAIL rapply_post_tick it=%0d got %b want %b", it, tick, exp_t); end
            if (strobe !== 3'b000)  begin mismatched++; $display("FAIL rapply_post_strobe it=%0d got %b want 000", it, strobe); end
            if (en_mask !== 3'b000) begin mismatched++; $display("FAIL rapply_post_en_mask it=%0d got %b want 000", it, en_mask); end
            if (cfg_ready !== 1'b1) begin mismatched++; $display("FAIL rapply_post_ready it=%0d got %b want 1", it, cfg_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_back_to_back();
        test_sync();
        test_invalid_and_disable();
        test_div_max();
        test_reset_in_apply();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
